// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: CPU port 0 has priority, loader/debug port 1
// is force-granted after STARVE_LIMIT consecutive denied cycles.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt;
    logic       force1;
    logic       rv0_q;
    logic       rv1_q;

    always_comb begin
        force1    = req1 && (wait_cnt == LIMIT);
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!reset) begin
            if (force1)
                gnt1 = 1'b1;
            else if (req0)
                gnt0 = 1'b1;
            else if (req1)
                gnt1 = 1'b1;
        end
        if (gnt0) begin
            mem_en    = 1'b1;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
        end else begin
            rv0_q <= gnt0 && !we0;
            rv1_q <= gnt1 && !we1;
            if (!req1 || gnt1)
                wait_cnt <= '0;
            else if (wait_cnt != LIMIT)
                wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Gating with reset kills a response still in flight when reset arrives.
    assign rvalid0 = rv0_q && !reset;
    assign rvalid1 = rv1_q && !reset;
    assign rdata0  = rvalid0 ? mem_rdata : '0;
    assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed vectors push expected grants and
// read data; a negedge monitor pops and compares.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic [15:0] mem [256];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        g0;
        logic        g1;
        logic        en;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wd;
        bit          zero;
    } exp_t;

    exp_t        eq[$];
    logic [15:0] rd0_q[$];
    logic [15:0] rd1_q[$];

    mem_arbiter #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(16),
        .STARVE_LIMIT(4)
    ) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // Synchronous RAM model behind the arbiter
    always @(posedge clock) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("gnt0", gnt0, e.g0);
            chk("gnt1", gnt1, e.g1);
            chk("mem_en", mem_en, e.en);
            chk("mem_we", mem_we, e.we);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_wdata", mem_wdata, e.wd);
            if (e.zero) begin
                chk("rvalid0_zero", rvalid0, 0);
                chk("rvalid1_zero", rvalid1, 0);
            end
        end
        if (rvalid0) begin
            if (rd0_q.size() > 0) chk("rdata0", rdata0, rd0_q.pop_front());
            else chk("rvalid0_unexpected", rvalid0, 0);
        end else begin
            chk("rdata0_idle", rdata0, 0);
        end
        if (rvalid1) begin
            if (rd1_q.size() > 0) chk("rdata1", rdata1, rd1_q.pop_front());
            else chk("rvalid1_unexpected", rvalid1, 0);
        end else begin
            chk("rdata1_idle", rdata1, 0);
        end
    end

    task automatic step(input logic rst,
                        input logic q0, input logic w0,
                        input logic [7:0] a0, input logic [15:0] d0,
                        input logic q1, input logic w1,
                        input logic [7:0] a1, input logic [15:0] d1,
                        input logic e0, input logic e1,
                        input bit rd, input logic [15:0] erd, input bit z);
        exp_t e;
        @(posedge clock);
        #1;
        reset = rst;
        req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;
        e.g0   = e0;
        e.g1   = e1;
        e.en   = e0 | e1;
        e.we   = e0 ? w0 : (e1 ? w1 : 1'b0);
        e.addr = e0 ? a0 : (e1 ? a1 : 8'h00);
        e.wd   = e0 ? d0 : (e1 ? d1 : 16'h0000);
        e.zero = z;
        eq.push_back(e);
        if (rd && e0) rd0_q.push_back(erd);
        if (rd && e1) rd1_q.push_back(erd);
    endtask

    task automatic idle(input int n, input bit z);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 16'h0, z);
    endtask

    initial begin
        // Reset with both ports requesting: everything held at zero
        step(1, 1, 0, 8'h11, 16'h1, 1, 0, 8'h22, 16'h2, 0, 0, 0, 16'h0, 1);
        step(1, 1, 1, 8'h11, 16'h1, 1, 1, 8'h22, 16'h2, 0, 0, 0, 16'h0, 1);

        // Write then read on port 0
        step(0, 1, 1, 8'h10, 16'h0008, 0, 0, 8'h00, 16'h0, 1, 0, 0, 16'h0, 0);
        step(0, 1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0, 1, 0, 1, 16'h0008, 0);
        idle(1, 0);
        idle(10, 1);

        // Continuous contention: port 1 forced every fifth cycle
        for (int i = 1; i <= 15; i++) begin
            bit f;
            f = (i % 5 == 0);
            step(0, 1, 1, 8'h20, 16'h1234, 1, 1, 8'h40, 16'hBEEF,
                 !f, f, 0, 16'h0, 0);
        end
        idle(1, 0);

        // Preload 1,2,3 with 5,6,7, then pipelined port 1 reads
        step(0, 1, 1, 8'h01, 16'h5, 0, 0, 8'h00, 16'h0, 1, 0, 0, 16'h0, 0);
        step(0, 1, 1, 8'h02, 16'h6, 0, 0, 8'h00, 16'h0, 1, 0, 0, 16'h0, 0);
        step(0, 1, 1, 8'h03, 16'h7, 0, 0, 8'h00, 16'h0, 1, 0, 0, 16'h0, 0);
        step(0, 0, 0, 8'h00, 16'h0, 1, 0, 8'h01, 16'h0, 0, 1, 1, 16'h5, 0);
        step(0, 0, 0, 8'h00, 16'h0, 1, 0, 8'h02, 16'h0, 0, 1, 1, 16'h6, 0);
        step(0, 0, 0, 8'h00, 16'h0, 1, 0, 8'h03, 16'h0, 0, 1, 1, 16'h7, 0);
        idle(2, 0);

        // Withdraw: 3 denied, drop for 1, then 4 denied before the force
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 8'h50, 16'hAAAA, 1, 0, 8'h01, 16'h0, 1, 0, 0, 16'h0, 0);
        step(0, 1, 1, 8'h50, 16'hAAAA, 0, 0, 8'h01, 16'h0, 1, 0, 0, 16'h0, 0);
        for (int i = 0; i < 4; i++)
            step(0, 1, 1, 8'h50, 16'hAAAA, 1, 0, 8'h01, 16'h0, 1, 0, 0, 16'h0, 0);
        step(0, 1, 1, 8'h50, 16'hAAAA, 1, 0, 8'h01, 16'h0, 0, 1, 1, 16'h5, 0);
        idle(2, 0);

        // Port 1 alone: immediate grant, then read back the write
        step(0, 0, 0, 8'h00, 16'h0, 1, 1, 8'h60, 16'h0077, 0, 1, 0, 16'h0, 0);
        step(0, 0, 0, 8'h00, 16'h0, 1, 0, 8'h60, 16'h0000, 0, 1, 1, 16'h0077, 0);
        idle(1, 0);

        // Reset the cycle after a read grant: response must vanish
        step(0, 1, 0, 8'h02, 16'h0, 0, 0, 8'h00, 16'h0, 1, 0, 0, 16'h0, 0);
        step(1, 1, 0, 8'h03, 16'h0, 1, 0, 8'h01, 16'h0, 0, 0, 0, 16'h0, 1);
        idle(3, 1);

        // First cycle after reset: port 0 wins with a fresh wait count
        step(0, 1, 0, 8'h03, 16'h0, 1, 0, 8'h02, 16'h0, 1, 0, 1, 16'h7, 0);
        idle(2, 0);

        @(posedge clock);
        @(negedge clock);
        #1;
        chk("exp_left", eq.size(), 0);
        chk("rd0_left", rd0_q.size(), 0);
        chk("rd1_left", rd1_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
